// File: rtl/wb_arbiter.sv
// wb_arbiter: merges single-cycle (port A) and multi-cycle (port B) results
// onto one register-file write port. Port-B results wait in a FIFO and are
// guaranteed service through a starvation counter and a one-cycle DRAIN state.
// Optional macro WB_ARBITER_BYPASS_EN adds two combinational forwarding taps
// on the registered write port.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [4:0]                    a_rd,
  input  logic [63:0]                   a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [4:0]                    b_rd,
  input  logic [63:0]                   b_data,
  output logic [4:0]                    w_addr,
  output logic [63:0]                   w_data,
  output logic                          w_ena,
`ifdef WB_ARBITER_BYPASS_EN
  input  logic [4:0]                    r_addr1,
  input  logic [4:0]                    r_addr2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [63:0]                   fwd_data1,
  output logic [63:0]                   fwd_data2,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    wAddr_q, wAddr_d;
  logic [63:0]   wData_q, wData_d;
  logic          wEna_q, wEna_d;
  logic [68:0]   mem_q [FIFO_DEPTH];

  logic          aWin, push, pop, qNonEmpty, toDrain;
  logic [68:0]   head;

  // Handshakes: both ports are held off while reset is asserted; A is also
  // held off for the single DRAIN cycle.
  always_comb begin
    a_ready   = rst & (state_q == NORMAL);
    b_ready   = rst & (count_q < COUNT_FULL);
    qNonEmpty = (count_q != '0);
    aWin      = a_valid & a_ready;
    push      = b_valid & b_ready;
    pop       = rst & qNonEmpty & ((state_q == DRAIN) | ~a_valid);
    head      = mem_q[rdPtr_q];
    toDrain   = (state_q == NORMAL) & aWin & qNonEmpty &
                ((count_q == COUNT_FULL) | (starve_q == STARVE_LAST));
  end

  // Next-state computation for queue pointers, arbitration state and write port.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    wEna_d   = 1'b0;
    wAddr_d  = wAddr_q;
    wData_d  = wData_q;

    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (aWin) begin
      wAddr_d = a_rd;
      wData_d = a_data;
      wEna_d  = (a_rd != 5'd0);
    end else if (pop) begin
      wAddr_d = head[68:64];
      wData_d = head[63:0];
      wEna_d  = (head[68:64] != 5'd0);
    end

    if (pop)
      starve_d = '0;
    else if (aWin && qNonEmpty && (starve_q != STARVE_LAST))
      starve_d = starve_q + SW'(1);

    case (state_q)
      NORMAL:  state_d = toDrain ? DRAIN : NORMAL;
      DRAIN:   state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Arbitration FSM, queue bookkeeping and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      wEna_q   <= 1'b0;
      wAddr_q  <= '0;
      wData_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      wEna_q   <= wEna_d;
      wAddr_q  <= wAddr_d;
      wData_q  <= wData_d;
    end
  end

  // Queue storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {b_rd, b_data};
  end

  assign w_ena   = wEna_q;
  assign w_addr  = wAddr_q;
  assign w_data  = wData_q;
  assign q_count = count_q;

`ifdef WB_ARBITER_BYPASS_EN
  // Forwarding taps: x0 never hits, so a zero read address always sees no forward.
  always_comb begin
    fwd_hit1  = wEna_q & (wAddr_q == r_addr1) & (r_addr1 != 5'd0);
    fwd_hit2  = wEna_q & (wAddr_q == r_addr2) & (r_addr2 != 5'd0);
    fwd_data1 = fwd_hit1 ? wData_q : 64'd0;
    fwd_data2 = fwd_hit2 ? wData_q : 64'd0;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus for wb_arbiter, checked against a
// transaction-level model (queue of pending port-B results plus a count of
// port-A wins since the queue was last serviced).
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready, w_ena;
  logic [4:0]  a_rd, b_rd, w_addr;
  logic [63:0] a_data, b_data, w_data;
  logic [$clog2(DEPTH):0] q_count;
`ifdef WB_ARBITER_BYPASS_EN
  logic [4:0]  r_addr1, r_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
`endif

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .w_addr(w_addr), .w_data(w_data), .w_ena(w_ena),
`ifdef WB_ARBITER_BYPASS_EN
    .r_addr1(r_addr1), .r_addr2(r_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [68:0] pending[$];
  int          aWinsSinceService;
  bit          aBlocked;
  bit          expEna;
  logic [4:0]  expAddr;
  logic [63:0] expData;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check handshakes mid-cycle, advance the model across the edge,
  // then check the registered outputs just after the edge.
  task automatic applyStimulus(input bit rn, input bit av, input logic [4:0] ard, input logic [63:0] ad,
                               input bit bv, input logic [4:0] brd, input logic [63:0] bd);
    bit          expAR, expBR, aWon, served;
    logic [68:0] item;
    rst = rn; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
`ifdef WB_ARBITER_BYPASS_EN
    r_addr1 = ($urandom_range(0, 3) == 0) ? 5'd0 : expAddr;
    r_addr2 = 5'($urandom);
`endif
    #3;
    expAR = rn && !aBlocked;
    expBR = rn && (pending.size() < DEPTH);
    checkOutput("a_ready", 64'(a_ready), 64'(expAR));
    checkOutput("b_ready", 64'(b_ready), 64'(expBR));
`ifdef WB_ARBITER_BYPASS_EN
    checkOutput("fwd_hit1", 64'(fwd_hit1), 64'(expEna && expAddr == r_addr1 && r_addr1 != 0));
    checkOutput("fwd_data1", fwd_data1, (expEna && expAddr == r_addr1 && r_addr1 != 0) ? expData : 64'd0);
`endif
    @(posedge clk);
    if (!rn) begin
      pending.delete();
      aWinsSinceService = 0;
      aBlocked = 0;
      expEna = 0; expAddr = 0; expData = 0;
    end else begin
      aWon = expAR && av;
      served = !aWon && pending.size() > 0;
      if (aWon) begin
        expEna = (ard != 0); expAddr = ard; expData = ad;
        if (pending.size() > 0) begin
          aBlocked = (pending.size() == DEPTH) || (aWinsSinceService >= SMAX - 1);
          aWinsSinceService++;
        end
      end else begin
        aBlocked = 0;
        if (served) begin
          item = pending.pop_front();
          expEna = (item[68:64] != 0); expAddr = item[68:64]; expData = item[63:0];
          aWinsSinceService = 0;
        end else begin
          expEna = 0;
        end
      end
      if (bv && expBR) pending.push_back({brd, bd});
    end
    #1;
    checkOutput("w_ena", 64'(w_ena), 64'(expEna));
    checkOutput("q_count", 64'(q_count), 64'(pending.size()));
    if (expEna || !rn) begin
      checkOutput("w_addr", 64'(w_addr), 64'(expAddr));
      checkOutput("w_data", w_data, expData);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    aWinsSinceService = 0; aBlocked = 0; expEna = 0; expAddr = 0; expData = 0;
    rst = 0; a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
`ifdef WB_ARBITER_BYPASS_EN
    r_addr1 = 0; r_addr2 = 0;
`endif
    @(posedge clk); #1;

    // Reset state.
    applyStimulus(0, 1, 5'd3, 64'h11, 1, 5'd4, 64'h22);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Single port-A result right after reset.
    applyStimulus(1, 1, 5'd5, 64'h1234, 0, 0, 0);
    checkOutput("dir_a_addr", 64'(w_addr), 64'd5);
    checkOutput("dir_a_data", w_data, 64'h1234);
    idle(1);

    // Single port-B result, two-cycle latency.
    applyStimulus(1, 0, 0, 0, 1, 5'd7, 64'hAA);
    checkOutput("dir_b_cnt1", 64'(q_count), 64'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("dir_b_ena", 64'(w_ena), 64'd1);
    checkOutput("dir_b_addr", 64'(w_addr), 64'd7);
    idle(2);

    // A held high while the queue fills: full-queue drain.
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1, 5'(i + 1), 64'h100 + 64'(i), (i < 6), 5'(i + 10), 64'h200 + 64'(i));
    idle(6);

    // A held high with one queued entry: starvation-triggered drain.
    applyStimulus(1, 1, 5'd1, 64'h301, 1, 5'd9, 64'h399);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 5'(i + 2), 64'h302 + 64'(i), 0, 0, 0);
    idle(2);

    // x0 destination on port A is consumed silently.
    applyStimulus(1, 1, 5'd0, 64'hDEAD, 0, 0, 0);
    checkOutput("x0_ena", 64'(w_ena), 64'd0);
    idle(1);

    // Reset with three entries queued: they must never be written.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 5'(20 + i), 64'h400 + 64'(i), 1, 5'(25 + i), 64'h500 + 64'(i));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    idle(6);

    // Random traffic with occasional resets and x0 destinations.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 59) != 0,
                    $urandom_range(0, 2) != 0, 5'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 1) != 0, 5'($urandom), {$urandom, $urandom});
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
